// File: rtl/alu_cmd_frontend_if.sv
// Byte-stream link between the host side and the ALU command frontend.
// Carries the inbound command byte stream and the outbound response byte stream.
interface alu_cmd_frontend_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  // Host side: sources command bytes, sinks response bytes.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Frontend side: sinks command bytes, sources response bytes.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/alu_cmd_frontend.sv
// ALU command frontend: assembles 5-byte frames (A hi/lo, B hi/lo, opcode),
// drives the ALU operands, waits ALU_LAT cycles, then returns the 16-bit
// result as two response bytes (high byte first).
module alu_cmd_frontend #(
  parameter int ALU_LAT = 1,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_cmd_frontend_if.slave    link,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic [3:0]           alu_op,
  input  logic [15:0]          alu_result,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_W-1:0]     cmd_count
);

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_RST = 4'b0001;

  typedef enum logic [1:0] {ST_RX, ST_EXEC, ST_TX_HI, ST_TX_LO} state_t;

  state_t            state, state_next;
  logic [2:0]        byte_idx;
  logic [7:0]        frame_buf [4];
  logic [15:0]       res;
  logic [LAT_W-1:0]  lat_cnt;
  logic [TO_W-1:0]   idle_cnt;

  logic       in_fire;
  logic       out_fire;
  logic       last_byte;
  logic       lat_done;
  logic       idle_expired;
  logic [3:0] new_op;
  logic       new_op_alu;

  // Opcodes that the ALU executes and that produce a response.
  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010,
      4'b1011, 4'b1100, 4'b1101: is_alu_op = 1'b1;
      default:                   is_alu_op = 1'b0;
    endcase
  endfunction

  assign in_fire      = link.in_valid && (state == ST_RX);
  assign out_fire     = link.out_ready && ((state == ST_TX_HI) || (state == ST_TX_LO));
  assign last_byte    = in_fire && (byte_idx == 3'd4);
  assign new_op       = link.in_data[3:0];
  assign new_op_alu   = is_alu_op(new_op);
  assign lat_done     = (lat_cnt == LAT_W'(ALU_LAT - 1));
  assign idle_expired = (TIMEOUT != 0) && (idle_cnt == TO_W'(TIMEOUT - 1));
  assign busy         = (byte_idx != 3'd0) || (state != ST_RX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RX;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default up front so no path leaves it unassigned (no latch).
    state_next     = state;
    link.in_ready  = 1'b0;
    link.out_valid = 1'b0;
    link.out_data  = 8'h00;
    case (state)
      ST_RX: begin
        link.in_ready = 1'b1;
        if (last_byte && new_op_alu) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (lat_done) state_next = ST_TX_HI;
      end
      ST_TX_HI: begin
        link.out_valid = 1'b1;
        link.out_data  = res[15:8];
        if (link.out_ready) state_next = ST_TX_LO;
      end
      ST_TX_LO: begin
        link.out_valid = 1'b1;
        link.out_data  = res[7:0];
        if (link.out_ready) state_next = ST_RX;
      end
      default: state_next = ST_RX;
    endcase
  end

  // Partial-frame byte storage; only bytes below byte_idx are ever read.
  // NOTE: this storage has no reset; its contents are meaningless until written and byte_idx guards every read.
  always_ff @(posedge clk) begin
    if (in_fire && (byte_idx != 3'd4)) frame_buf[byte_idx[1:0]] <= link.in_data;
  end

  // Frame assembly, opcode handling, timeout, latency wait and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx  <= 3'd0;
      alu_a     <= 16'h0000;
      alu_b     <= 16'h0000;
      alu_op    <= OP_NOP;
      err       <= 1'b0;
      cmd_count <= '0;
      res       <= 16'h0000;
      lat_cnt   <= '0;
      idle_cnt  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
      // The RST opcode is a single-cycle pulse on alu_op.
      if (alu_op == OP_RST) alu_op <= OP_NOP;

      if (in_fire) begin
        idle_cnt <= '0;
        if (last_byte) begin
          byte_idx <= 3'd0;
          alu_a    <= {frame_buf[0], frame_buf[1]};
          alu_b    <= {frame_buf[2], frame_buf[3]};
          if (new_op == OP_NOP) begin
            alu_op <= OP_NOP;
          end else if (new_op == OP_RST) begin
            alu_op    <= OP_RST;
            err       <= 1'b0;
            cmd_count <= '0;
          end else if (new_op_alu) begin
            alu_op <= new_op;
          end else begin
            alu_op <= OP_NOP;
            err    <= 1'b1;
          end
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
      end else if ((state == ST_RX) && (byte_idx != 3'd0) && (TIMEOUT != 0)) begin
        if (idle_expired) begin
          byte_idx <= 3'd0;
          idle_cnt <= '0;
          err      <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TO_W'(1);
        end
      end else begin
        idle_cnt <= '0;
      end

      if (state == ST_EXEC) begin
        if (lat_done) begin
          res     <= alu_result;
          lat_cnt <= '0;
        end else begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
      end

      if (out_fire && (state == ST_TX_LO)) cmd_count <= cmd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Directed bench for alu_cmd_frontend with a small behavioural ALU attached.
module tb_alu_cmd_frontend;
  logic        clk;
  logic        reset;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        busy, err;
  logic [15:0] cmd_count;

  int vectors     = 0;
  int miscompares = 0;

  alu_cmd_frontend_if link ();

  alu_cmd_frontend #(.ALU_LAT(1), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .link       (link),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy),
    .err        (err),
    .cmd_count  (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU (combinational, 16-bit wrap).
  always_comb begin
    case (alu_op)
      4'b0100: alu_result = alu_a + alu_b;
      4'b0101: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b);
    int n = 0;
    link.in_valid = 1'b1;
    link.in_data  = b;
    while (!link.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!link.in_ready) check({tag, " in_ready wait"}, link.in_ready, 1);
    @(posedge clk); #1;
    link.in_valid = 1'b0;
  endtask

  task automatic send_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] op);
    send_byte(tag, a[15:8]);
    send_byte(tag, a[7:0]);
    send_byte(tag, b[15:8]);
    send_byte(tag, b[7:0]);
    send_byte(tag, op);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    link.out_ready = 1'b1;
    while (!link.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " out_valid"}, link.out_valid, 1);
    check({tag, " out_data"}, link.out_data, exp);
    @(posedge clk); #1;
    link.out_ready = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic seen = 1'b0;
    link.out_ready = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (link.out_valid) seen = 1'b1;
    end
    link.out_ready = 1'b0;
    check(tag, seen, 0);
  endtask

  task automatic hit_reset(input string tag);
    link.in_valid  = 1'b0;
    link.out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check({tag, " out_valid"}, link.out_valid, 0);
    check({tag, " out_data"},  link.out_data, 0);
    check({tag, " in_ready"},  link.in_ready, 1);
    check({tag, " alu_a"},     alu_a, 0);
    check({tag, " alu_b"},     alu_b, 0);
    check({tag, " alu_op"},    alu_op, 0);
    check({tag, " err"},       err, 0);
    check({tag, " cmd_count"}, cmd_count, 0);
    check({tag, " busy"},      busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic bad;
    reset          = 1'b0;
    link.in_valid  = 1'b0;
    link.in_data   = 8'h00;
    link.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready",  link.in_ready, 1);
    check("rst out_valid", link.out_valid, 0);
    check("rst out_data",  link.out_data, 0);
    check("rst alu_a",     alu_a, 0);
    check("rst alu_op",    alu_op, 0);
    check("rst err",       err, 0);
    check("rst cmd_count", cmd_count, 0);
    check("rst busy",      busy, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ADD 1234h + 0001h
    send_frame("add", 16'h1234, 16'h0001, 8'h04);
    check("add alu_a",    alu_a, 16'h1234);
    check("add alu_b",    alu_b, 16'h0001);
    check("add alu_op",   alu_op, 4'h4);
    check("add in_ready", link.in_ready, 0);
    check("add busy",     busy, 1);
    recv_byte("add hi", 8'h12);
    recv_byte("add lo", 8'h35);
    check("add cmd_count", cmd_count, 1);
    check("add idle out_valid", link.out_valid, 0);

    // SUB wraps, then NOP yields nothing
    send_frame("sub", 16'h0000, 16'h0001, 8'h05);
    recv_byte("sub hi", 8'hFF);
    recv_byte("sub lo", 8'hFF);
    check("sub cmd_count", cmd_count, 2);
    send_frame("nop", 16'h0000, 16'h0000, 8'h00);
    check("nop alu_op", alu_op, 0);
    expect_quiet("nop no response", 6);
    check("nop cmd_count", cmd_count, 2);
    check("nop busy", busy, 0);

    // Illegal opcode (upper nibble ignored), then RST
    send_frame("ill", 16'h1111, 16'h2222, 8'hFE);
    check("ill err",    err, 1);
    check("ill alu_op", alu_op, 0);
    expect_quiet("ill no response", 6);
    send_frame("rstop", 16'h0000, 16'h0000, 8'h01);
    check("rstop alu_op pulse", alu_op, 1);
    check("rstop err",          err, 0);
    check("rstop cmd_count",    cmd_count, 0);
    @(posedge clk); #1;
    check("rstop alu_op after", alu_op, 0);
    expect_quiet("rstop no response", 4);

    // Backpressure in TX_HI for 20 cycles
    send_frame("bp", 16'h1210, 16'h0020, 8'h04);
    @(posedge clk); #1;
    bad = 1'b0;
    repeat (20) begin
      if (link.out_valid !== 1'b1 || link.out_data !== 8'h12 || link.in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("bp hold stable", bad, 0);
    recv_byte("bp hi", 8'h12);
    recv_byte("bp lo", 8'h30);
    check("bp cmd_count", cmd_count, 1);

    // Partial frame timeout (TIMEOUT=8)
    send_byte("to", 8'hAB);
    send_byte("to", 8'hCD);
    check("to busy partial", busy, 1);
    repeat (7) @(posedge clk);
    #1;
    check("to err before", err, 0);
    check("to busy before", busy, 1);
    @(posedge clk); #1;
    check("to err fired", err, 1);
    check("to busy cleared", busy, 0);
    send_frame("xor", 16'hAAAA, 16'h5555, 8'h0A);
    recv_byte("xor hi", 8'hFF);
    recv_byte("xor lo", 8'hFF);
    check("xor cmd_count", cmd_count, 2);
    check("xor err sticky", err, 1);

    // Reset during EXEC
    send_frame("rx", 16'h0001, 16'h0001, 8'h04);
    hit_reset("rst exec");
    send_frame("post1", 16'h0002, 16'h0003, 8'h04);
    recv_byte("post1 hi", 8'h00);
    // Reset during TX_LO
    hit_reset("rst txlo");
    send_frame("post2", 16'h0005, 16'h0007, 8'h04);
    recv_byte("post2 hi", 8'h00);
    recv_byte("post2 lo", 8'h0C);
    check("post2 cmd_count", cmd_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
